// File: rtl/pitch_resampler.sv
// Variable-rate sample resampler: streams 32-bit SDRAM words (two 16-bit samples each)
// through a cur/nxt window and writes one 16-bit sample per step to SRAM.
// Optional macro PITCH_LINEAR_INTERP_EN enables linear interpolation; otherwise zero-order hold.
module pitch_resampler #(
  parameter int ADDR_W  = 23,
  parameter int SRAM_AW = 20,
  parameter int STEP_W  = 8,
  parameter int FRAC_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               pitch_start,
  input  logic [ADDR_W-1:0]  pitch_select_start,
  input  logic [ADDR_W-1:0]  pitch_select_end,
  input  logic               pitch_mode,
  input  logic [STEP_W-1:0]  pitch_step,
  output logic               pitch_done,
  output logic               pitch_read,
  output logic [ADDR_W-1:0]  pitch_addr,
  input  logic [31:0]        pitch_readdata,
  input  logic               pitch_sdram_finished,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_WDATA,
  output logic               SRAM_WE_N
);

  localparam int IW = ADDR_W + 2;
  localparam int PW = IW + FRAC_W;

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, CALC, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   start_q, start_d, end_q, end_d, addr_q, addr_d;
  logic                mode_q, mode_d, init_q, init_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [IW-1:0]       wi_q, wi_d;
  logic [15:0]         cur_q, cur_d, nxt_q, nxt_d, spare_q, spare_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;

  logic [ADDR_W:0]     span;
  logic [IW-1:0]       nsamp, pos_i, next_i, wi_plus2;
  logic [PW-1:0]       pos_next;
  logic [15:0]         first_half, second_half, interp;

  assign span       = {1'b0, end_q} - {1'b0, start_q} + (ADDR_W+1)'(1);
  assign nsamp      = {span, 1'b0};
  assign pos_i      = pos_q[PW-1:FRAC_W];
  assign pos_next   = pos_q + {{(PW-STEP_W){1'b0}}, step_q};
  assign next_i     = pos_next[PW-1:FRAC_W];
  assign wi_plus2   = wi_q + IW'(2);
  // Reverse playback walks words downward, so the high half comes first.
  assign first_half  = mode_q ? pitch_readdata[31:16] : pitch_readdata[15:0];
  assign second_half = mode_q ? pitch_readdata[15:0]  : pitch_readdata[31:16];

`ifdef PITCH_LINEAR_INTERP_EN
  logic signed [16:0] diff;
  assign diff   = $signed({nxt_q[15], nxt_q}) - $signed({cur_q[15], cur_q});
  assign interp = cur_q + 16'(($signed({{(FRAC_W+1){diff[16]}}, diff})
                  * $signed({18'b0, pos_q[FRAC_W-1:0]})) >>> FRAC_W);
`else
  assign interp = cur_q;
`endif

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    end_d       = end_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    init_d      = init_q;
    step_d      = step_q;
    pos_d       = pos_q;
    wi_d        = wi_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    spare_d     = spare_q;
    wdata_d     = wdata_q;
    sram_addr_d = sram_addr_q;
    case (state_q)
      IDLE: if (pitch_start) begin
        start_d     = pitch_select_start;
        end_d       = pitch_select_end;
        mode_d      = pitch_mode;
        step_d      = (pitch_step == '0) ? {{(STEP_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}}
                                         : pitch_step;
        pos_d       = '0;
        wi_d        = '0;
        sram_addr_d = '0;
        init_d      = 1'b1;
        addr_d      = pitch_mode ? pitch_select_end : pitch_select_start;
        state_d     = (pitch_select_start > pitch_select_end) ? DONE : FETCH;
      end
      FETCH: if (pitch_sdram_finished) begin
        addr_d = mode_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        if (init_q) begin
          cur_d  = first_half;
          nxt_d  = second_half;
          init_d = 1'b0;
          wi_d   = '0;
        end else begin
          cur_d   = nxt_q;
          nxt_d   = first_half;
          spare_d = second_half;
          wi_d    = wi_q + IW'(1);
        end
        state_d = SHIFT;
      end
      // Odd window index: next sample is the buffered second half of the last word.
      SHIFT: begin
        if (wi_q == pos_i) begin
          state_d = CALC;
        end else if (wi_q[0]) begin
          cur_d = nxt_q;
          nxt_d = spare_q;
          wi_d  = wi_q + IW'(1);
        end else if (wi_plus2 >= nsamp) begin
          cur_d = nxt_q;
          wi_d  = wi_q + IW'(1);
        end else begin
          state_d = FETCH;
        end
      end
      CALC: begin
        wdata_d = interp;
        state_d = WRITE;
      end
      WRITE: begin
        sram_addr_d = sram_addr_q + SRAM_AW'(1);
        pos_d       = pos_next;
        state_d     = (sram_addr_q == '1 || next_i >= nsamp) ? DONE : SHIFT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      start_q     <= '0;
      end_q       <= '0;
      addr_q      <= '0;
      mode_q      <= 1'b0;
      init_q      <= 1'b0;
      step_q      <= '0;
      pos_q       <= '0;
      wi_q        <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      spare_q     <= '0;
      wdata_q     <= '0;
      sram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      end_q       <= end_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      init_q      <= init_d;
      step_q      <= step_d;
      pos_q       <= pos_d;
      wi_q        <= wi_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      spare_q     <= spare_d;
      wdata_q     <= wdata_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  assign pitch_read = (state_q == FETCH);
  assign pitch_done = (state_q == DONE);
  assign SRAM_WE_N  = (state_q != WRITE);
  assign pitch_addr = addr_q;
  assign SRAM_ADDR  = sram_addr_q;
  assign SRAM_WDATA = wdata_q;

endmodule

// File: doc/pitch_resampler.md
PITCH_RESAMPLER -- requirements
Module: pitch_resampler

Interface
REQ-001 SHALL have parameter ADDR_W, 23, SDRAM word-address width.
REQ-002 SHALL have parameter SRAM_AW, 20, SRAM output address width.
REQ-003 SHALL have parameter STEP_W, 8, playback step width (unsigned fixed point).
REQ-004 SHALL have parameter FRAC_W, 4, fractional bits of step; FRAC_W < STEP_W.
REQ-005 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pitch_start  in  1  one-cycle start pulse.
REQ-008 SHALL have port pitch_select_start / pitch_select_end  in  ADDR_W each  first/last SDRAM word, inclusive.
REQ-009 SHALL have port pitch_mode  in  1  0 forward, 1 reverse.
REQ-010 SHALL have port pitch_step  in  STEP_W  samples advanced per output, in units of 2^-FRAC_W.
REQ-011 SHALL have port pitch_done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port pitch_read  out  1  SDRAM read request.
REQ-013 SHALL have port pitch_addr  out  ADDR_W  SDRAM word address.
REQ-014 SHALL have port pitch_readdata  in  32  two signed 16-bit samples, [15:0] earlier in forward order.
REQ-015 SHALL have port pitch_sdram_finished  in  1  read-data-valid strobe.
REQ-016 SHALL have ports SRAM_ADDR  out  SRAM_AW; SRAM_WDATA  out  16; SRAM_WE_N  out  1 (active-low write strobe).

Function
REQ-017 SHALL implement states IDLE, FETCH, SHIFT, CALC, WRITE, DONE.
REQ-018 IDLE: pitch_start latches select/mode/step, clears position and SRAM_ADDR, enters FETCH; pitch_start outside IDLE SHALL be ignored.
REQ-019 pitch_step = 0 SHALL be treated as 2^FRAC_W (1.0x).
REQ-020 FETCH: pitch_read high, pitch_addr stable until the cycle pitch_sdram_finished=1; data captured that cycle; pitch_read low next cycle; no timeout.
REQ-021 Forward reads start..end ascending, low half first; reverse reads end..start descending, high half first.
REQ-022 SHALL hold a two-sample window cur/nxt; sample index N = 2*(end-start+1); nxt past last sample SHALL equal cur.
REQ-023 Position = integer part I + FRAC_W-bit fraction F; SHIFT advances window one sample per cycle until window index equals I, issuing FETCH when a new word is needed.
REQ-024 CALC: out = cur + ((nxt - cur) * F) >>> FRAC_W, 17-bit signed difference, arithmetic (floor) shift, result 16 bits.
REQ-025 WRITE: SRAM_WE_N low exactly one cycle with SRAM_WDATA=out at current SRAM_ADDR; then SRAM_ADDR+1, position += step, go SHIFT.
REQ-026 When I > N-1 after advance, SHALL enter DONE without writing.
REQ-027 After 2^SRAM_AW writes (SRAM_ADDR wraps to 0) SHALL enter DONE immediately.
REQ-028 DONE: pitch_done high one cycle, return to IDLE.
REQ-029 start > end SHALL be treated as an empty range: DONE without any read.

Reset
REQ-030 i_rst_n low SHALL immediately force IDLE, pitch_done=0, pitch_read=0, pitch_addr=0, SRAM_ADDR=0, SRAM_WDATA=0, SRAM_WE_N=1, window/position cleared, including mid-transfer.

Configuration
REQ-031 With macro PITCH_LINEAR_INTERP_EN defined, CALC SHALL use REQ-024; undefined, out = cur (zero-order hold), F ignored, multiplier absent.

Verification
REQ-032 step=16, start=0,end=1, words 0x00020001,0x00040003 -> SRAM[0..3]=1,2,3,4, 2 reads, one done pulse.
REQ-033 step=8, start=end=0, word 0x00100000 -> with macro writes 0,8,16,16; without macro 0,0,16,16.
REQ-034 step=32, words as REQ-032 -> writes 1,3 then done; step=0 -> identical to REQ-032.
REQ-035 pitch_mode=1, words as REQ-032 -> first pitch_addr=1, writes 4,3,2,1.
REQ-036 pitch_sdram_finished held low 10 cycles -> pitch_read/pitch_addr stable, SRAM_WE_N high throughout, result unchanged.
REQ-037 i_rst_n low during FETCH -> pitch_read=0, SRAM_WE_N=1 same instant; new pitch_start after release runs REQ-032 cleanly.
